// File: rtl/uc_pkg.sv
// Shared definitions for the unit-clause path: literal width, queue size and
// the literal type used by per-engine queues and the arbiter wrapper.
package uc_pkg;
    localparam int UC_LENGTH = 1024;
    localparam int LIT_W     = $clog2(UC_LENGTH);
    localparam int UCQ_SIZE  = 16;

    typedef logic signed [LIT_W-1:0] lit_t;

    localparam lit_t LIT_NONE = '0;
endpackage

// File: rtl/ucq_match.sv
// Combinational lookup of an incoming literal against the occupied queue
// entries; reports an exact match (duplicate) and a negated match (conflict).
module ucq_match import uc_pkg::*; #(
    parameter int  DEPTH = UCQ_SIZE,
    parameter int  LIT_W = uc_pkg::LIT_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic signed [LIT_W-1:0] push_lit,
    input  logic signed [LIT_W-1:0] mem [DEPTH],
    input  logic        [PTR_W-1:0] rd_ptr,
    input  logic        [CNT_W-1:0] count,
    output logic                    dup_hit,
    output logic                    neg_hit
);
    logic [PTR_W-1:0]        w_off [DEPTH];
    logic [DEPTH-1:0]        w_occ;
    logic signed [LIT_W-1:0] w_neg;

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below the count, which covers the wrapped case for free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PTR_W'(i) - rd_ptr;
            w_occ[i] = ({1'b0, w_off[i]} < count);
        end
    end

    always_comb begin
        dup_hit = 1'b0;
        neg_hit = 1'b0;
        w_neg   = -push_lit;
        for (int i = 0; i < DEPTH; i++) begin
            dup_hit = dup_hit | (w_occ[i] && (mem[i] == push_lit));
            neg_hit = neg_hit | (w_occ[i] && (mem[i] == w_neg));
        end
    end
endmodule

// File: rtl/eng_ucq.sv
// Per-engine unit-clause FIFO feeding the unit-clause arbiter: deduplicates
// pushes, flags pushes that contradict a queued literal, sticky overflow.
module eng_ucq import uc_pkg::*; #(
    parameter int  DEPTH = UCQ_SIZE,
    parameter int  LIT_W = uc_pkg::LIT_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_valid,
    input  logic signed [LIT_W-1:0] push_lit,
    input  logic                    pop,
    output logic signed [LIT_W-1:0] eng2uca_min,
    output logic                    eng2uca_valid,
    output logic                    eng2uca_empty,
    output logic                    ucq_full,
    output logic        [CNT_W-1:0] ucq_count,
    output logic                    conflict,
    output logic                    overflow
);
    localparam logic signed [LIT_W-1:0] LIT_MOST_NEG = {1'b1, {(LIT_W-1){1'b0}}};

    logic signed [LIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_conflict;
    logic                    r_overflow;

    logic w_dup_hit, w_neg_hit;
    logic w_pop_eff, w_lit_ok, w_fresh, w_room, w_accept, w_drop_full;

    ucq_match #(.DEPTH(DEPTH), .LIT_W(LIT_W)) u_match (
        .push_lit (push_lit),
        .mem      (r_mem),
        .rd_ptr   (r_rd_ptr),
        .count    (r_count),
        .dup_hit  (w_dup_hit),
        .neg_hit  (w_neg_hit)
    );

    assign w_pop_eff   = pop && (r_count != '0);
    assign w_lit_ok    = push_valid && (push_lit != '0) && (push_lit != LIT_MOST_NEG);
    assign w_fresh     = w_lit_ok && !w_dup_hit && !w_neg_hit;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_room      = (r_count != CNT_W'(DEPTH)) || w_pop_eff;
    assign w_accept    = w_fresh && w_room;
    assign w_drop_full = w_fresh && !w_room;

    // Storage carries no reset; stale slots are masked by the occupancy logic.
    always_ff @(posedge clk) begin
        if (!flush && w_accept) begin
            r_mem[r_wr_ptr] <= push_lit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_conflict <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_conflict <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop_eff})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_conflict <= w_lit_ok && w_neg_hit;
            r_overflow <= r_overflow | w_drop_full;
        end
    end

    assign eng2uca_valid = (r_count != '0);
    assign eng2uca_empty = (r_count == '0);
    assign eng2uca_min   = eng2uca_valid ? r_mem[r_rd_ptr] : LIT_W'(LIT_NONE);
    assign ucq_full      = (r_count == CNT_W'(DEPTH));
    assign ucq_count     = r_count;
    assign conflict      = r_conflict;
    assign overflow      = r_overflow;
endmodule
